uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART serializer that sends one bit per tx_clk edge.
// Latency: the start bit appears one edge after a write into an empty FIFO with the serializer idle.
// Backpressure: none; a write while full is dropped and recorded in the sticky overflow flag.
//
// Ports:
//   tx_clk    bit-rate clock (one rising edge per bit)   rst       async active-high reset
//   wr_en     write strobe                               wr_data   entry to enqueue
//   ovf_clr   clears overflow                            uart_txd  serial line, idles high
//   full      FIFO holds 2**DEPTH_LOG2 entries           empty     FIFO holds no entries
//   count     FIFO occupancy                             busy      serializer not in IDLE
//   overflow  sticky flag, set by a dropped write
module uart_tx_fifo #(
   parameter int DATA_BW    = 8,
   parameter int DEPTH_LOG2 = 3,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                  tx_clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_BW-1:0]    wr_data,
   input  logic                  ovf_clr,
   output logic                  uart_txd,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  busy,
   output logic                  overflow
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int IDX_W = $clog2(DATA_BW);

   typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
   logic                    stop_cnt_q, stop_cnt_d;
   logic                    start_q, start_d;
   logic [DATA_BW-1:0]      shift_q, shift_d;
   logic                    txd_q, txd_d;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]     count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic [DATA_BW-1:0]      mem_q [DEPTH];

   logic                    pop;
   logic                    wr_acc;
   logic                    last_data;
   logic                    last_stop;

   assign full      = (count_q == (DEPTH_LOG2+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign busy      = (state_q != IDLE);
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign uart_txd  = txd_q;

   assign last_data = (bit_idx_q == IDX_W'(DATA_BW-1));
   assign last_stop = (stop_cnt_q == 1'(STOP_BITS-1));

   // State register (serializer and FIFO bookkeeping)
   always_ff @(posedge tx_clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_idx_q  <= '0;
         stop_cnt_q <= 1'b0;
         start_q    <= 1'b0;
         shift_q    <= '0;
         txd_q      <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         start_q    <= start_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge tx_clk) begin
      if (wr_acc && !rst) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      start_d    = start_q;
      case (state_q)
         IDLE: begin
            // The start bit goes out on the popping edge itself.
            if (!empty) begin
               state_d   = DATA;
               bit_idx_d = '0;
               start_d   = 1'b0;
            end
         end
         DATA: begin
            if (start_q) begin
               start_d = 1'b0;
            end else if (last_data) begin
               state_d    = (PARITY != 0) ? PAR : STOP;
               stop_cnt_d = 1'b0;
            end else begin
               bit_idx_d = bit_idx_q + 1'b1;
            end
         end
         PAR: begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
         end
         STOP: begin
            if (!last_stop) begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end else if (!empty) begin
               // Entry popped on the final stop edge; start_q makes the next
               // DATA edge emit the start bit so frames abut without an idle bit.
               state_d   = DATA;
               bit_idx_d = '0;
               start_d   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath logic: line value, pop strobe, shift register load
   always_comb begin
      pop     = 1'b0;
      txd_d   = 1'b1;
      shift_d = shift_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               txd_d   = 1'b0;
            end
         end
         DATA:    txd_d = start_q ? 1'b0 : shift_q[bit_idx_q];
         PAR:     txd_d = (PARITY == 2) ? ~(^shift_q) : (^shift_q);
         STOP: begin
            if (last_stop && !empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
            end
         end
         default: txd_d = 1'b1;
      endcase
   end

   // FIFO pointers, occupancy and overflow flag
   always_comb begin
      wr_acc   = wr_en && !full;
      wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({wr_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // A dropped write wins over a simultaneous clear.
      if (wr_en && full) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: bench for uart_tx_fifo, four parameter variants on shared stimulus.
// Instance 0: defaults; 1: even parity; 2: odd parity; 3: two stop bits.
// A monitor decodes frames on the selected instance; tests compare them with expected frames.
module tb_uart_tx_fifo;

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic       stop_ok;
      int         start_cyc;
      int         end_cyc;
   } frame_t;

   logic       tx_clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       ovf_clr;
   logic [3:0] txd_w, full_w, empty_w, busy_w, ovf_w;
   logic [3:0] cnt_w [4];

   int     cyc = 0;
   int     mon_sel = 0;
   int     n_chk = 0;
   int     n_fail = 0;
   frame_t exp_q[$];
   frame_t obs_q[$];

   uart_tx_fifo u_p0 (
      .tx_clk(tx_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
      .uart_txd(txd_w[0]), .full(full_w[0]), .empty(empty_w[0]), .count(cnt_w[0]),
      .busy(busy_w[0]), .overflow(ovf_w[0]));

   uart_tx_fifo #(.PARITY(1)) u_pe (
      .tx_clk(tx_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
      .uart_txd(txd_w[1]), .full(full_w[1]), .empty(empty_w[1]), .count(cnt_w[1]),
      .busy(busy_w[1]), .overflow(ovf_w[1]));

   uart_tx_fifo #(.PARITY(2)) u_po (
      .tx_clk(tx_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
      .uart_txd(txd_w[2]), .full(full_w[2]), .empty(empty_w[2]), .count(cnt_w[2]),
      .busy(busy_w[2]), .overflow(ovf_w[2]));

   uart_tx_fifo #(.STOP_BITS(2)) u_s2 (
      .tx_clk(tx_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
      .uart_txd(txd_w[3]), .full(full_w[3]), .empty(empty_w[3]), .count(cnt_w[3]),
      .busy(busy_w[3]), .overflow(ovf_w[3]));

   initial begin
      tx_clk = 1'b0;
      forever #5 tx_clk = ~tx_clk;
   end

   always @(posedge tx_clk) cyc <= cyc + 1;

   // Frame monitor: samples the selected line on falling edges, i.e. after
   // the rising edge numbered cyc. Any reset abandons a partial frame.
   initial begin : monitor
      frame_t f;
      int     st;
      int     idx;
      int     sidx;
      int     nstop;
      bit     haspar;
      logic   b;
      st = 0; idx = 0; sidx = 0; f = '0;
      forever begin
         @(negedge tx_clk);
         b      = txd_w[mon_sel];
         haspar = (mon_sel == 1) || (mon_sel == 2);
         nstop  = (mon_sel == 3) ? 2 : 1;
         if (rst) begin
            st = 0;
         end else begin
            case (st)
               0: if (b === 1'b0) begin
                     f = '0; f.start_cyc = cyc; f.stop_ok = 1'b1; idx = 0; st = 1;
                  end
               1: begin
                     f.data[idx] = b; idx++;
                     if (idx == 8) begin st = haspar ? 2 : 3; sidx = 0; end
                  end
               2: begin f.par = b; st = 3; end
               3: begin
                     if (b !== 1'b1) f.stop_ok = 1'b0;
                     sidx++;
                     if (sidx == nstop) begin f.end_cyc = cyc; obs_q.push_back(f); st = 0; end
                  end
               default: st = 0;
            endcase
         end
      end
   end

   function automatic frame_t mk(input logic [7:0] d, input logic p, input int s, input int len);
      frame_t f;
      f.data = d; f.par = p; f.stop_ok = 1'b1; f.start_cyc = s; f.end_cyc = s + len - 1;
      return f;
   endfunction

   function automatic string fs(input frame_t f);
      return $sformatf("data %h par %b stop_ok %b start %0d end %0d",
                       f.data, f.par, f.stop_ok, f.start_cyc, f.end_cyc);
   endfunction

   task automatic wait_obs(input int budget);
      for (int t = 0; t < budget; t++) begin
         if (obs_q.size() != 0) break;
         @(negedge tx_clk); #1;
      end
   endtask

   task automatic do_reset();
      @(negedge tx_clk);
      rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0;
      @(negedge tx_clk);
      @(negedge tx_clk);
      rst = 1'b0;
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset();
      @(negedge tx_clk);
      rst = 1'b1;
      #1;
      n_chk++; if (txd_w !== 4'hF)    begin n_fail++; $display("FAIL reset_txd: got %b want 1111", txd_w); end
      n_chk++; if (cnt_w[0] !== 4'd0)  begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt_w[0]); end
      n_chk++; if (empty_w[0] !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty_w[0]); end
      n_chk++; if (full_w[0] !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full_w[0]); end
      n_chk++; if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_w[0]); end
      n_chk++; if (ovf_w[0] !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_w[0]); end
      @(negedge tx_clk);
      rst = 1'b0;
   endtask

   // 0x55 into an idle block: start, 1,0,1,0,1,0,1,0, stop, then idle high.
   task automatic test_basic();
      logic [10:0] pat;
      int          w;
      frame_t      e, o;
      pat = 11'b11010101010;
      do_reset(); mon_sel = 0;
      @(negedge tx_clk); wr_en = 1'b1; wr_data = 8'h55; w = cyc + 1;
      exp_q.push_back(mk(8'h55, 1'b0, w + 1, 10));
      @(negedge tx_clk); wr_en = 1'b0;
      n_chk++; if (cnt_w[0] !== 4'd1) begin n_fail++; $display("FAIL basic_count_wr: got %0d want 1", cnt_w[0]); end
      n_chk++; if (txd_w[0] !== 1'b1) begin n_fail++; $display("FAIL basic_idle_txd: got %b want 1", txd_w[0]); end
      for (int i = 0; i < 11; i++) begin
         @(negedge tx_clk);
         n_chk++;
         if (txd_w[0] !== pat[i]) begin n_fail++; $display("FAIL basic_bit%0d: got %b want %b", i, txd_w[0], pat[i]); end
         if (i == 0) begin
            n_chk++; if (cnt_w[0] !== 4'd0) begin n_fail++; $display("FAIL basic_count_pop: got %0d want 0", cnt_w[0]); end
         end
         if (i == 8) begin
            n_chk++; if (busy_w[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid: got %b want 1", busy_w[0]); end
         end
         if (i == 9) begin
            n_chk++; if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b want 0", busy_w[0]); end
         end
      end
      wait_obs(5);
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL basic_frame: got none want %s", fs(exp_q[0])); end
      else begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         if (o !== e) begin n_fail++; $display("FAIL basic_frame: got %s want %s", fs(o), fs(e)); end
      end
   endtask

   // 0xA5 has four set bits: even parity bit 0, odd parity bit 1, 11-edge frame.
   task automatic test_parity();
      int     w;
      frame_t e, o;
      for (int pm = 1; pm <= 2; pm++) begin
         do_reset(); mon_sel = pm;
         @(negedge tx_clk); wr_en = 1'b1; wr_data = 8'hA5; w = cyc + 1;
         exp_q.push_back(mk(8'hA5, (pm == 1) ? 1'b0 : 1'b1, w + 1, 11));
         @(negedge tx_clk); wr_en = 1'b0;
         wait_obs(30);
         n_chk++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL parity%0d_frame: got none want %s", pm, fs(exp_q[0])); end
         else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL parity%0d_frame: got %s want %s", pm, fs(o), fs(e)); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int     w;
      frame_t e, o;
      do_reset(); mon_sel = 0;
      @(negedge tx_clk); wr_en = 1'b1; wr_data = 8'h01; w = cyc + 1;
      exp_q.push_back(mk(8'h01, 1'b0, w + 1, 10));
      @(negedge tx_clk); wr_data = 8'h80;
      exp_q.push_back(mk(8'h80, 1'b0, w + 11, 10));
      @(negedge tx_clk); wr_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wait_obs(30);
         n_chk++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_frame%0d: got none want %s", k, fs(exp_q[0])); end
         else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL b2b_frame%0d: got %s want %s", k, fs(o), fs(e)); end
         end
      end
      n_chk++; if (cnt_w[0] !== 4'd0)  begin n_fail++; $display("FAIL b2b_count: got %0d want 0", cnt_w[0]); end
      n_chk++; if (empty_w[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", empty_w[0]); end
      n_chk++; if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: got %b want 0", busy_w[0]); end
   endtask

   // Ten consecutive writes: nine accepted (one slot freed by the first pop), the tenth dropped.
   task automatic test_overflow();
      int     w;
      frame_t e, o;
      do_reset(); mon_sel = 0;
      w = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge tx_clk);
         if (i == 9) begin
            n_chk++; if (cnt_w[0] !== 4'd8) begin n_fail++; $display("FAIL ovf_count_full: got %0d want 8", cnt_w[0]); end
            n_chk++; if (full_w[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full_w[0]); end
            n_chk++; if (ovf_w[0] !== 1'b0)  begin n_fail++; $display("FAIL ovf_before_drop: got %b want 0", ovf_w[0]); end
         end
         wr_en = 1'b1; wr_data = 8'(8'h10 + i); ovf_clr = (i == 9);
         if (i == 0) w = cyc + 1;
         if (i < 9) exp_q.push_back(mk(8'(8'h10 + i), 1'b0, w + 1 + 10 * i, 10));
      end
      @(negedge tx_clk); wr_en = 1'b0; ovf_clr = 1'b1;
      n_chk++; if (ovf_w[0] !== 1'b1)  begin n_fail++; $display("FAIL ovf_drop_beats_clr: got %b want 1", ovf_w[0]); end
      n_chk++; if (cnt_w[0] !== 4'd8) begin n_fail++; $display("FAIL ovf_count_drop: got %0d want 8", cnt_w[0]); end
      @(negedge tx_clk); ovf_clr = 1'b0;
      n_chk++; if (ovf_w[0] !== 1'b0)  begin n_fail++; $display("FAIL ovf_clr: got %b want 0", ovf_w[0]); end
      n_chk++; if (cnt_w[0] !== 4'd7) begin n_fail++; $display("FAIL ovf_count_pop: got %0d want 7", cnt_w[0]); end
      n_chk++; if (full_w[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_not_full: got %b want 0", full_w[0]); end
      for (int k = 0; k < 9; k++) begin
         wait_obs(30);
         n_chk++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL ovf_frame%0d: got none want %s", k, fs(exp_q[0])); end
         else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL ovf_frame%0d: got %s want %s", k, fs(o), fs(e)); end
         end
      end
      n_chk++; if (cnt_w[0] !== 4'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d want 0", cnt_w[0]); end
   endtask

   task automatic test_stop2();
      int     w;
      frame_t e, o;
      do_reset(); mon_sel = 3;
      @(negedge tx_clk); wr_en = 1'b1; wr_data = 8'h3C; w = cyc + 1;
      exp_q.push_back(mk(8'h3C, 1'b0, w + 1, 11));
      @(negedge tx_clk); wr_data = 8'hC3;
      exp_q.push_back(mk(8'hC3, 1'b0, w + 12, 11));
      @(negedge tx_clk); wr_en = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wait_obs(30);
         n_chk++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL stop2_frame%0d: got none want %s", k, fs(exp_q[0])); end
         else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o !== e) begin n_fail++; $display("FAIL stop2_frame%0d: got %s want %s", k, fs(o), fs(e)); end
         end
      end
   endtask

   // Reset at data bit 4 of 0x00 with 0x5A still queued: the line rises at once,
   // the queued entry is lost, writes during reset are ignored.
   task automatic test_reset_mid();
      int     w;
      frame_t e, o;
      do_reset(); mon_sel = 0;
      @(negedge tx_clk); wr_en = 1'b1; wr_data = 8'h00;
      @(negedge tx_clk); wr_data = 8'h5A;
      @(negedge tx_clk); wr_en = 1'b0;
      repeat (5) @(negedge tx_clk);
      n_chk++; if (txd_w[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit4: got %b want 0", txd_w[0]); end
      n_chk++; if (cnt_w[0] !== 4'd1) begin n_fail++; $display("FAIL rstmid_count_pre: got %0d want 1", cnt_w[0]); end
      rst = 1'b1;
      #1;
      n_chk++; if (txd_w[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_txd: got %b want 1", txd_w[0]); end
      n_chk++; if (cnt_w[0] !== 4'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", cnt_w[0]); end
      n_chk++; if (busy_w[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_w[0]); end
      wr_en = 1'b1; wr_data = 8'hEE;
      @(negedge tx_clk);
      n_chk++; if (cnt_w[0] !== 4'd0) begin n_fail++; $display("FAIL rstmid_wr_ignored: got %0d want 0", cnt_w[0]); end
      wr_en = 1'b0; rst = 1'b0;
      exp_q.delete(); obs_q.delete();
      @(negedge tx_clk); wr_en = 1'b1; wr_data = 8'h96; w = cyc + 1;
      exp_q.push_back(mk(8'h96, 1'b0, w + 1, 10));
      @(negedge tx_clk); wr_en = 1'b0;
      wait_obs(30);
      n_chk++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL rstmid_frame: got none want %s", fs(exp_q[0])); end
      else begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         if (o !== e) begin n_fail++; $display("FAIL rstmid_frame: got %s want %s", fs(o), fs(e)); end
      end
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_overflow();
      test_stop2();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
